countdown_sched: RTL and testbench

Two-requester scheduler that shares one 3-bit loadable down-counter (synchronous load, decrement by one per clock, 0 wraps to 7 if not reloaded) between two clients. It arbitrates round-robin, loads the winner's length into the counter, watches the count for terminal zero, and pulses that client's `done`. Between jobs it parks the counter at 0 so the counter never wraps. It sits beside the counter in the timing/sequencing subsystem; clients never drive the counter directly.

---
 rtl/countdown_sched_if.sv | 16 +
 rtl/countdown_sched.sv | 79 +++++++
 tb/tb_countdown_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_sched_if.sv
// countdown_sched_if: client bundle (request/length in, grant/done/busy out) for countdown_sched
// Ports: req0/req1, len0/len1 from the clients; gnt0/gnt1, done0/done1, busy back to them.
// COUNTDOWN_SCHED_ABORT_EN adds abort (client -> scheduler) and aborted (scheduler -> client).
interface countdown_sched_if #(parameter int CW = 3);
  logic req0, req1;
  logic [CW-1:0] len0, len1;
  logic gnt0, gnt1, done0, done1, busy;
`ifdef COUNTDOWN_SCHED_ABORT_EN
  logic abort, aborted;
  modport master (output req0, req1, len0, len1, abort, input gnt0, gnt1, done0, done1, busy, aborted);
  modport slave (input req0, req1, len0, len1, abort, output gnt0, gnt1, done0, done1, busy, aborted);
`else
  modport master (output req0, req1, len0, len1, input gnt0, gnt1, done0, done1, busy);
  modport slave (input req0, req1, len0, len1, output gnt0, gnt1, done0, done1, busy);
`endif
endinterface

// File: rtl/countdown_sched.sv
// countdown_sched: round-robin sharing of one loadable down-counter between two clients
// Ports: clk, reset (async, active low), bus (countdown_sched_if.slave client bundle),
//   cnt_load/cnt_din drive the counter, cnt_count is its current value.
// COUNTDOWN_SCHED_ABORT_EN enables the abort/aborted pair for cancelling a job in LOAD or RUN.
module countdown_sched #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  countdown_sched_if.slave bus,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_din,
  input  logic [CW-1:0] cnt_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic [CW-1:0] len_q, len_d;
  logic gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic zero, win, pick, abort_hit;
  always_comb begin
    zero = cnt_count == '0;
    win = state_q == IDLE && (bus.req0 || bus.req1);
    pick = bus.req0 && bus.req1 ? prio_q : bus.req1;
`ifdef COUNTDOWN_SCHED_ABORT_EN
    abort_hit = bus.abort && (state_q == LOAD || state_q == RUN);
`else
    abort_hit = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = win ? LOAD : IDLE;
      LOAD: state_d = RUN;
      RUN: state_d = zero ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
    owner_d = win ? pick : owner_q;
    len_d = win ? (pick ? bus.len1 : bus.len0) : len_q;
    prio_d = state_q == DONE || abort_hit ? ~owner_q : prio_q;
    // Loading whenever the count is 0 (or outside RUN) keeps the counter from wrapping to all-ones.
    cnt_load = state_q != RUN || zero || abort_hit;
    cnt_din = state_q == LOAD && !abort_hit ? len_q : '0;
  end
`ifdef COUNTDOWN_SCHED_ABORT_EN
  logic aborted_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) aborted_q <= 1'b0;
    else aborted_q <= abort_hit;
  assign bus.aborted = aborted_q;
`endif
  // Pulse outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
      len_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q <= prio_d;
      len_q <= len_d;
      gnt0_q <= state_d == LOAD && !owner_d;
      gnt1_q <= state_d == LOAD && owner_d;
      done0_q <= state_d == DONE && !owner_d;
      done1_q <= state_d == DONE && owner_d;
      busy_q <= state_d != IDLE;
    end
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_countdown_sched.sv
// tb_countdown_sched: scoreboard bench for countdown_sched with a behavioural counter beside it
module tb_countdown_sched;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cnt_load;
  logic [CW-1:0] cnt_din;
  logic [CW-1:0] cnt_count = CW'(5);
  int errors = 0, checks = 0, cyc = 0;
  int gcyc = 0, cur_len = 0, k = 0, abort_cyc = -10, c0 = 0, g = 0;
  bit active = 1'b0;
  typedef struct { bit c; int len; } job_t;
  job_t sb[$];
  countdown_sched_if #(.CW(CW)) bus();
  countdown_sched #(.CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cnt_load(cnt_load), .cnt_din(cnt_din), .cnt_count(cnt_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) cnt_count <= cnt_load ? cnt_din : cnt_count - CW'(1);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) active = 1'b0;
    else begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_while_busy", active, 0);
        check("gnt_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("gnt_client", bus.gnt1, sb[0].c);
          check("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
          active = 1'b1;
          gcyc = cyc;
          cur_len = sb[0].len;
        end
      end
`ifdef COUNTDOWN_SCHED_ABORT_EN
      if (active && cyc == abort_cyc + 1) begin
        check("aborted_pulse", bus.aborted, 1);
        void'(sb.pop_front());
        active = 1'b0;
      end else check("aborted_quiet", bus.aborted, 0);
`endif
      if (active) begin
        k = cyc - gcyc - 1;
        check("busy", bus.busy, 1);
        if (k >= 0 && k <= cur_len) check("count", cnt_count, cur_len - k);
      end else begin
        check("idle_busy", bus.busy, 0);
        check("idle_count", cnt_count, 0);
      end
      if (bus.done0 || bus.done1) begin
        check("done_pending", active, 1);
        if (active) begin
          check("done_client", bus.done1, sb[0].c);
          check("done_onehot", bus.done0 & bus.done1, 0);
          check("done_cyc", cyc, gcyc + 2 + cur_len);
          void'(sb.pop_front());
          active = 1'b0;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.gnt0) bus.req0 = 1'b0;
    if (bus.gnt1) bus.req1 = 1'b0;
  endtask
  task automatic issue(input bit c, input int len);
    sb.push_back('{c, len});
    if (c) begin
      bus.req1 = 1'b1;
      bus.len1 = CW'(len);
    end else begin
      bus.req0 = 1'b1;
      bus.len0 = CW'(len);
    end
  endtask
  task automatic wait_gnt(input bit c, input int from, input int lat);
    int n = 0;
    bit hit;
    do begin
      step();
      n++;
      hit = c ? bus.gnt1 : bus.gnt0;
    end while (!hit && n < 40);
    check(c ? "gnt1_lat" : "gnt0_lat", hit ? cyc - from : -1, lat);
  endtask
  task automatic drain();
    int n = 0;
    do begin
      step();
      n++;
    end while ((bus.busy || sb.size() != 0) && n < 80);
    check("drain", sb.size(), 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {bus.gnt0, bus.gnt1}, 0);
    check({tag, "_done"}, {bus.done0, bus.done1}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_load"}, cnt_load, 1);
    check({tag, "_din"}, cnt_din, 0);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = '0;
    bus.len1 = '0;
`ifdef COUNTDOWN_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check("post_rst_count", cnt_count, 0);
    // both clients pending from reset: client 0 favoured, then alternation
    issue(0, 2);
    issue(1, 5);
    c0 = cyc;
    wait_gnt(0, c0, 1);
    wait_gnt(1, c0, 7);
    g = cyc;
    step();
    issue(0, 4);
    issue(1, 1);
    wait_gnt(0, g, 9);
    g = cyc;
    wait_gnt(1, g, 8);
    drain();
    // single client jobs, including zero and maximum lengths
    issue(0, 3);
    c0 = cyc;
    wait_gnt(0, c0, 1);
    drain();
    issue(1, 0);
    c0 = cyc;
    wait_gnt(1, c0, 1);
    drain();
    issue(0, 7);
    c0 = cyc;
    wait_gnt(0, c0, 1);
    drain();
    // reset in the middle of a run aborts without done
    issue(0, 6);
    c0 = cyc;
    wait_gnt(0, c0, 1);
    repeat (3) step();
    check("mid_count", cnt_count, 4);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    step();
    reset = 1'b1;
    step();
    check("mid_rst_count", cnt_count, 0);
    repeat (12) step();
`ifdef COUNTDOWN_SCHED_ABORT_EN
    issue(0, 7);
    c0 = cyc;
    wait_gnt(0, c0, 1);
    issue(1, 2);
    repeat (3) step();
    check("abort_count", cnt_count, 5);
    bus.abort = 1'b1;
    abort_cyc = cyc;
    step();
    bus.abort = 1'b0;
    check("abort_load0", cnt_count, 0);
    wait_gnt(1, abort_cyc, 2);
    drain();
`endif
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
